// File: rtl/ddr5_ctrl_pkg.sv
// Shared definitions for the DDR5-style command sequencer: FSM encoding, CA opcodes
// and the word-address field layout.
package ddr5_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACT,
        ST_TRCD_W,
        ST_CMD,
        ST_LAT_W,
        ST_DATA0,
        ST_DATA1,
        ST_PRE,
        ST_TRP_W
    } state_t;

    localparam logic [2:0] OP_ACT = 3'b001;
    localparam logic [2:0] OP_WR  = 3'b010;
    localparam logic [2:0] OP_RD  = 3'b011;
    localparam logic [2:0] OP_PRE = 3'b100;

    localparam int COL_LSB  = 0;
    localparam int COL_W    = 6;
    localparam int BANK_LSB = 6;
    localparam int BANK_W   = 2;
    localparam int ROW_LSB  = 8;
    localparam int ROW_W    = 9;
    // Word-address bits above this width do not exist in the DRAM.
    localparam int DRAM_ADDR_W = ROW_LSB + ROW_W;

    function automatic logic [COL_W-1:0] addr_col(input logic [DRAM_ADDR_W-1:0] a);
        return a[COL_LSB +: COL_W];
    endfunction

    function automatic logic [BANK_W-1:0] addr_bank(input logic [DRAM_ADDR_W-1:0] a);
        return a[BANK_LSB +: BANK_W];
    endfunction

    function automatic logic [ROW_W-1:0] addr_row(input logic [DRAM_ADDR_W-1:0] a);
        return a[ROW_LSB +: ROW_W];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count; head is visible on dout.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/top_top.sv
// Request-queue front end and ACT/CMD/PRE sequencer for a 16-bit DDR-style DRAM port.
// Build option: define RD_PRIORITY_EN to let reads win IDLE arbitration (writes win otherwise).
//
// state   | meaning
// IDLE    | arbitrate queues, discard null writes, answer out-of-range reads
// ACT     | row activate, CS low
// TRCD_W  | activate-to-command wait
// CMD     | WR or RD column command, CS low
// LAT_W   | write or read latency wait
// DATA0   | low half-word beat on DQ
// DATA1   | high half-word beat on DQ; reads complete here
// PRE     | bank precharge, CS low
// TRP_W   | precharge recovery wait
module top_top
    import ddr5_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TRCD       = 2,
    parameter int WLAT       = 2,
    parameter int RLAT       = 4,
    parameter int TRP        = 2
) (
    input  logic        axi_clk,
    input  logic        rst_n,
    input  logic        W_Valid,
    input  logic [31:0] W_Data,
    input  logic [3:0]  W_STRB,
    input  logic [31:0] W_Address,
    input  logic        R_Valid_Address_x,
    input  logic [31:0] R_Address,
    input  logic        R_Ready,
    output logic [31:0] R_Data,
    output logic        R_Error,
    output logic        R_Ready_Address,
    output logic        empty1,
    output logic        empty2,
    output logic        empty3,
    output logic        empty4,
    output logic        full2,
    output logic        full3,
    inout  wire  [15:0] DQ,
    output logic [13:0] CA,
    output logic        CS
);
    localparam logic [7:0] TRCD_LD = 8'(TRCD - 1);
    localparam logic [7:0] WLAT_LD = 8'(WLAT - 1);
    localparam logic [7:0] RLAT_LD = 8'(RLAT - 1);
    localparam logic [7:0] TRP_LD  = 8'(TRP - 1);

    logic        w_push, wd_pop, ra_pop, rd_push, rd_pop, full1, full4;
    logic [35:0] wd_dout;
    logic [31:0] wa_dout, ra_dout;
    logic [32:0] rd_din, rd_dout;
    logic        idle, wr_req, rd_req, take_wr, take_rd, wr_discard, rd_bad, start;
    logic        wa_hi_unused;
    logic        dq_oe;
    logic [15:0] dq_out;

    state_t                 state_q, state_d;
    logic                   is_wr_q;
    logic [DRAM_ADDR_W-1:0] addr_q;
    logic [31:0]            data_q;
    logic [7:0]             timer_q;

    assign w_push          = W_Valid && !full2;
    assign R_Ready_Address = !full4;
    assign rd_pop          = R_Ready && !empty1;

    sync_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk(axi_clk), .rst_n(rst_n), .push(rd_push), .pop(rd_pop),
        .din(rd_din), .dout(rd_dout), .empty(empty1), .full(full1)
    );
    sync_fifo #(.WIDTH(36), .DEPTH(FIFO_DEPTH)) u_fifo2 (
        .clk(axi_clk), .rst_n(rst_n), .push(w_push), .pop(wd_pop),
        .din({W_Data, W_STRB}), .dout(wd_dout), .empty(empty2), .full(full2)
    );
    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo3 (
        .clk(axi_clk), .rst_n(rst_n), .push(w_push), .pop(wd_pop),
        .din(W_Address), .dout(wa_dout), .empty(empty3), .full(full3)
    );
    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo4 (
        .clk(axi_clk), .rst_n(rst_n), .push(R_Valid_Address_x && R_Ready_Address), .pop(ra_pop),
        .din(R_Address), .dout(ra_dout), .empty(empty4), .full(full4)
    );

    assign R_Data  = empty1 ? 32'h0 : rd_dout[31:0];
    assign R_Error = rd_dout[32] && !empty1;

    // A read is only taken when its completion slot in FIFO1 is guaranteed.
    assign idle   = (state_q == ST_IDLE);
    assign wr_req = !empty2;
    assign rd_req = !empty4 && !full1;
`ifdef RD_PRIORITY_EN
    assign take_rd = idle && rd_req;
    assign take_wr = idle && wr_req && !rd_req;
`else
    assign take_wr = idle && wr_req;
    assign take_rd = idle && rd_req && !wr_req;
`endif
    assign wr_discard   = take_wr && (wd_dout[3:0] == 4'h0);
    assign rd_bad       = take_rd && (ra_dout[31:DRAM_ADDR_W] != '0);
    assign start        = (take_wr && !wr_discard) || (take_rd && !rd_bad);
    assign wd_pop       = take_wr;
    assign ra_pop       = take_rd;
    assign rd_push      = rd_bad || (state_q == ST_DATA1 && !is_wr_q);
    assign rd_din       = rd_bad ? {1'b1, 32'h0} : {1'b0, DQ, data_q[15:0]};
    assign wa_hi_unused = ^wa_dout[31:DRAM_ADDR_W];

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_ACT;
            ST_ACT:    state_d = ST_TRCD_W;
            ST_TRCD_W: if (timer_q == '0) state_d = ST_CMD;
            ST_CMD:    state_d = ST_LAT_W;
            ST_LAT_W:  if (timer_q == '0) state_d = ST_DATA0;
            ST_DATA0:  state_d = ST_DATA1;
            ST_DATA1:  state_d = ST_PRE;
            ST_PRE:    state_d = ST_TRP_W;
            ST_TRP_W:  if (timer_q == '0) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            timer_q <= '0;
        end else begin
            if (take_wr) begin
                is_wr_q <= 1'b1;
                addr_q  <= wa_dout[DRAM_ADDR_W-1:0];
                data_q  <= wd_dout[35:4];
            end else if (take_rd) begin
                is_wr_q <= 1'b0;
                addr_q  <= ra_dout[DRAM_ADDR_W-1:0];
                data_q  <= '0;
            end
            case (state_q)
                ST_ACT:   timer_q <= TRCD_LD;
                ST_CMD:   timer_q <= is_wr_q ? WLAT_LD : RLAT_LD;
                ST_PRE:   timer_q <= TRP_LD;
                ST_TRCD_W, ST_LAT_W, ST_TRP_W:
                    if (timer_q != '0) timer_q <= timer_q - 8'd1;
                ST_DATA0: if (!is_wr_q) data_q[15:0]  <= DQ;
                ST_DATA1: if (!is_wr_q) data_q[31:16] <= DQ;
                default:  ;
            endcase
        end
    end

    always_comb begin
        CS     = 1'b1;
        CA     = '0;
        dq_oe  = 1'b0;
        dq_out = '0;
        case (state_q)
            ST_ACT: begin
                CS = 1'b0;
                CA = {OP_ACT, addr_bank(addr_q), addr_row(addr_q)};
            end
            ST_CMD: begin
                CS = 1'b0;
                CA = {(is_wr_q ? OP_WR : OP_RD), addr_bank(addr_q), 3'b000, addr_col(addr_q)};
            end
            ST_PRE: begin
                CS = 1'b0;
                CA = {OP_PRE, addr_bank(addr_q), 9'h0};
            end
            ST_DATA0: begin
                dq_oe  = is_wr_q;
                dq_out = data_q[15:0];
            end
            ST_DATA1: begin
                dq_oe  = is_wr_q;
                dq_out = data_q[31:16];
            end
            default: ;
        endcase
    end

    assign DQ = dq_oe ? dq_out : 16'hzzzz;

endmodule

// File: tb/tb_top_top.sv
// Directed self-checking bench for top_top: write/read sequencing, discards, errors,
// queue back-pressure and asynchronous reset mid-command.
module tb_top_top;
    localparam int TRCD = 2;
    localparam int WLAT = 2;
    localparam int RLAT = 4;
    localparam int TRP  = 2;

    logic        axi_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        W_Valid = 1'b0;
    logic [31:0] W_Data = '0;
    logic [3:0]  W_STRB = '0;
    logic [31:0] W_Address = '0;
    logic        R_Valid_Address_x = 1'b0;
    logic [31:0] R_Address = '0;
    logic        R_Ready = 1'b0;
    logic [31:0] R_Data;
    logic        R_Error, R_Ready_Address;
    logic        empty1, empty2, empty3, empty4, full2, full3;
    logic [13:0] CA;
    logic        CS;
    wire  [15:0] DQ;
    logic        tb_dq_oe = 1'b0;
    logic [15:0] tb_dq = '0;

    int checks = 0;
    int errors = 0;

    assign DQ = tb_dq_oe ? tb_dq : 16'hzzzz;

    always #5 axi_clk = ~axi_clk;

    top_top #(.FIFO_DEPTH(4), .TRCD(TRCD), .WLAT(WLAT), .RLAT(RLAT), .TRP(TRP)) dut (
        .axi_clk(axi_clk), .rst_n(rst_n),
        .W_Valid(W_Valid), .W_Data(W_Data), .W_STRB(W_STRB), .W_Address(W_Address),
        .R_Valid_Address_x(R_Valid_Address_x), .R_Address(R_Address), .R_Ready(R_Ready),
        .R_Data(R_Data), .R_Error(R_Error), .R_Ready_Address(R_Ready_Address),
        .empty1(empty1), .empty2(empty2), .empty3(empty3), .empty4(empty4),
        .full2(full2), .full3(full3), .DQ(DQ), .CA(CA), .CS(CS)
    );

    task automatic wait_cs(output logic [13:0] ca, output int n);
        ca = '0;
        n  = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge axi_clk);
            if (CS === 1'b0) begin
                ca = CA;
                n  = i;
                break;
            end
        end
    endtask

    task automatic push_write(input logic [31:0] d, input logic [3:0] s, input logic [31:0] a);
        @(negedge axi_clk);
        W_Valid = 1'b1; W_Data = d; W_STRB = s; W_Address = a;
        @(negedge axi_clk);
        W_Valid = 1'b0;
    endtask

    task automatic push_read(input logic [31:0] a);
        @(negedge axi_clk);
        R_Valid_Address_x = 1'b1; R_Address = a;
        @(negedge axi_clk);
        R_Valid_Address_x = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst_n = 1'b0;
        #1;
        got = {CS, empty1, empty2, empty3, empty4, full2, full3, R_Ready_Address, R_Error, 1'b0};
        checks++;
        if (got !== 10'b1_1111_00_1_0_0 || CA !== 14'h0 || R_Data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got flags=%b CA=%h R_Data=%h, expected flags=1111100100 CA=0000 R_Data=0", got, CA, R_Data);
        end
        repeat (2) @(negedge axi_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write(input string name, input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] a, input logic [1:0] bank,
                              input logic [8:0] row, input logic [5:0] col);
        logic [13:0] ca;
        int n;
        push_write(d, s, a);
        wait_cs(ca, n);
        checks++;
        if (n != 1 || ca !== {3'b001, bank, row}) begin
            errors++;
            $display("FAIL %s_act: got CA=%h after %0d cycles, expected CA=%h after 1", name, ca, n, {3'b001, bank, row});
        end
        checks++;
        if (empty2 !== 1'b1 || empty3 !== 1'b1) begin
            errors++;
            $display("FAIL %s_wq_empty: got empty2=%b empty3=%b, expected 1 1", name, empty2, empty3);
        end
        wait_cs(ca, n);
        checks++;
        if (n != TRCD + 1 || ca !== {3'b010, bank, 3'b000, col}) begin
            errors++;
            $display("FAIL %s_wr: got CA=%h after %0d cycles, expected CA=%h after %0d", name, ca, n, {3'b010, bank, 3'b000, col}, TRCD + 1);
        end
        repeat (WLAT + 1) @(negedge axi_clk);
        checks++;
        if (DQ !== d[15:0]) begin
            errors++;
            $display("FAIL %s_dq_lo: got DQ=%h, expected %h", name, DQ, d[15:0]);
        end
        @(negedge axi_clk);
        checks++;
        if (DQ !== d[31:16]) begin
            errors++;
            $display("FAIL %s_dq_hi: got DQ=%h, expected %h", name, DQ, d[31:16]);
        end
        wait_cs(ca, n);
        checks++;
        if (n != 1 || ca !== {3'b100, bank, 9'h0}) begin
            errors++;
            $display("FAIL %s_pre: got CA=%h after %0d cycles, expected CA=%h after 1", name, ca, n, {3'b100, bank, 9'h0});
        end
        repeat (TRP + 1) @(negedge axi_clk);
    endtask

    task automatic test_strb_zero();
        int cs_cnt = 0;
        push_write(32'hCAFEF00D, 4'h0, 32'h0000_4567);
        for (int i = 0; i < 12; i++) begin
            @(negedge axi_clk);
            if (CS === 1'b0) cs_cnt++;
        end
        checks++;
        if (cs_cnt != 0 || empty2 !== 1'b1) begin
            errors++;
            $display("FAIL strb_zero: got %0d CS pulses empty2=%b, expected 0 pulses empty2=1", cs_cnt, empty2);
        end
    endtask

    task automatic test_read();
        logic [13:0] ca;
        int n;
        push_read(32'h0000_4567);
        wait_cs(ca, n);
        checks++;
        if (n != 1 || ca !== {3'b001, 2'b01, 9'h045} || empty4 !== 1'b1) begin
            errors++;
            $display("FAIL rd_act: got CA=%h after %0d cycles empty4=%b, expected CA=%h after 1 empty4=1", ca, n, empty4, {3'b001, 2'b01, 9'h045});
        end
        wait_cs(ca, n);
        checks++;
        if (n != TRCD + 1 || ca !== {3'b011, 2'b01, 3'b000, 6'h27}) begin
            errors++;
            $display("FAIL rd_cmd: got CA=%h after %0d cycles, expected CA=%h after %0d", ca, n, {3'b011, 2'b01, 3'b000, 6'h27}, TRCD + 1);
        end
        repeat (RLAT + 1) @(negedge axi_clk);
        tb_dq_oe = 1'b1;
        tb_dq    = 16'hBEEF;
        #1;
        checks++;
        if (DQ !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_dq_free: got DQ=%h, expected BEEF (controller must not drive)", DQ);
        end
        @(negedge axi_clk);
        tb_dq = 16'hDEAD;
        @(negedge axi_clk);
        tb_dq_oe = 1'b0;
        checks++;
        if (CS !== 1'b0 || CA !== {3'b100, 2'b01, 9'h0}) begin
            errors++;
            $display("FAIL rd_pre: got CS=%b CA=%h, expected CS=0 CA=%h", CS, CA, {3'b100, 2'b01, 9'h0});
        end
        checks++;
        if (empty1 !== 1'b0 || R_Data !== 32'hDEADBEEF || R_Error !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: got empty1=%b R_Data=%h R_Error=%b, expected 0 DEADBEEF 0", empty1, R_Data, R_Error);
        end
        repeat (5) @(negedge axi_clk);
        checks++;
        if (empty1 !== 1'b0 || R_Data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_hold: got empty1=%b R_Data=%h, expected 0 DEADBEEF", empty1, R_Data);
        end
        R_Ready = 1'b1;
        @(negedge axi_clk);
        R_Ready = 1'b0;
        checks++;
        if (empty1 !== 1'b1 || R_Data !== 32'h0) begin
            errors++;
            $display("FAIL rd_pop: got empty1=%b R_Data=%h, expected 1 00000000", empty1, R_Data);
        end
    endtask

    task automatic test_read_error();
        int cs_cnt = 0;
        push_read(32'h0002_0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge axi_clk);
            if (CS === 1'b0) cs_cnt++;
        end
        checks++;
        if (cs_cnt != 0 || empty1 !== 1'b0 || R_Error !== 1'b1 || R_Data !== 32'h0) begin
            errors++;
            $display("FAIL rd_err: got %0d CS pulses empty1=%b R_Error=%b R_Data=%h, expected 0 0 1 00000000", cs_cnt, empty1, R_Error, R_Data);
        end
        R_Ready = 1'b1;
        @(negedge axi_clk);
        R_Ready = 1'b0;
        checks++;
        if (empty1 !== 1'b1 || R_Error !== 1'b0) begin
            errors++;
            $display("FAIL rd_err_pop: got empty1=%b R_Error=%b, expected 1 0", empty1, R_Error);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] ca;
        logic [5:0]  cols [8];
        int n;
        int wr_cnt = 0;
        push_write(32'h0, 4'hF, 32'h0000_003F);
        wait_cs(ca, n);
        wait_cs(ca, n);
        for (int i = 1; i <= 5; i++) begin
            @(negedge axi_clk);
            if (i == 5) begin
                checks++;
                if (full2 !== 1'b1 || full3 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_full4: got full2=%b full3=%b after 4 pushes, expected 1 1", full2, full3);
                end
            end
            W_Valid = 1'b1; W_Data = 32'(i); W_STRB = 4'hF; W_Address = 32'(i);
        end
        @(negedge axi_clk);
        W_Valid = 1'b0;
        checks++;
        if (full2 !== 1'b1 || full3 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_full5: got full2=%b full3=%b after 5th push, expected 1 1", full2, full3);
        end
        for (int c = 0; c < 150; c++) begin
            @(negedge axi_clk);
            if (CS === 1'b0 && CA[13:11] === 3'b010) begin
                if (wr_cnt < 8) cols[wr_cnt] = CA[5:0];
                wr_cnt++;
            end
        end
        checks++;
        if (wr_cnt != 4) begin
            errors++;
            $display("FAIL b2b_wr_count: got %0d WR commands, expected 4", wr_cnt);
        end else if (cols[0] !== 6'd1 || cols[1] !== 6'd2 || cols[2] !== 6'd3 || cols[3] !== 6'd4) begin
            errors++;
            $display("FAIL b2b_wr_cols: got cols %0d %0d %0d %0d, expected 1 2 3 4", cols[0], cols[1], cols[2], cols[3]);
        end
        checks++;
        if (empty2 !== 1'b1 || empty3 !== 1'b1 || full2 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got empty2=%b empty3=%b full2=%b, expected 1 1 0", empty2, empty3, full2);
        end
    endtask

    task automatic test_reset_inflight();
        logic [13:0] ca;
        logic [8:0]  got;
        int n;
        int cs_cnt = 0;
        push_write(32'hA5A55A5A, 4'hF, 32'h0000_4567);
        wait_cs(ca, n);
        @(negedge axi_clk);
        W_Valid = 1'b1; W_Data = 32'h1111_2222; W_STRB = 4'hF; W_Address = 32'h0000_0100;
        R_Valid_Address_x = 1'b1; R_Address = 32'h0000_0200;
        @(negedge axi_clk);
        W_Valid = 1'b0;
        R_Valid_Address_x = 1'b0;
        wait_cs(ca, n);
        checks++;
        if (n != 1 || ca[13:11] !== 3'b010) begin
            errors++;
            $display("FAIL rst_pre_cmd: got CA=%h after %0d cycles, expected WR after 1", ca, n);
        end
        @(negedge axi_clk);
        checks++;
        if (empty2 !== 1'b0 || empty4 !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre_queued: got empty2=%b empty4=%b, expected 0 0", empty2, empty4);
        end
        #2;
        rst_n = 1'b0;
        tb_dq_oe = 1'b1;
        tb_dq    = 16'h0000;
        #1;
        got = {CS, empty1, empty2, empty3, empty4, full2, full3, R_Ready_Address, R_Error};
        checks++;
        if (got !== 9'b1_1111_00_1_0 || CA !== 14'h0) begin
            errors++;
            $display("FAIL rst_async: got flags=%b CA=%h, expected flags=111110010 CA=0000", got, CA);
        end
        checks++;
        if (DQ !== 16'h0000) begin
            errors++;
            $display("FAIL rst_dq_released: got DQ=%h with bench driving 0000, expected 0000", DQ);
        end
        tb_dq_oe = 1'b0;
        @(negedge axi_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge axi_clk);
            if (CS === 1'b0) cs_cnt++;
        end
        checks++;
        if (cs_cnt != 0) begin
            errors++;
            $display("FAIL rst_no_pre: got %0d CS pulses after reset, expected 0", cs_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write("w1", 32'h14253679, 4'hF, 32'h0000_4567, 2'b01, 9'h045, 6'h27);
        test_write("w2", 32'h5148AECF, 4'hE, 32'h0000_4568, 2'b01, 9'h045, 6'h28);
        test_strb_zero();
        test_read();
        test_read_error();
        test_back_to_back();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/top_top.md
TOP_TOP -- requirements
Module: top_top

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH=4 (entries per queue); TRCD=2, WLAT=2, RLAT=4, TRP=2 (wait cycles).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports:
- axi_clk  in  1  sole clock, rising edge
- rst_n  in  1  async active-low reset
- W_Valid  in  1  write request push
- W_Data  in  32  write data
- W_STRB  in  4  byte strobes
- W_Address  in  32  write word address
- R_Valid_Address_x  in  1  read request push
- R_Address  in  32  read word address
- R_Ready  in  1  read data pop
- R_Data  out  32  read data FIFO head
- R_Error  out  1  head read entry is errored
- R_Ready_Address  out  1  read address FIFO not full
- empty1, empty2, empty3, empty4  out  1 each  read-data, write-data, write-address, read-address FIFO empty
- full2, full3  out  1 each  write-data, write-address FIFO full
- DQ  inout  16  DRAM data
- CA  out  14  DRAM command/address
- CS  out  1  DRAM chip select, active low

Function
REQ-004 SHALL push {W_Data,W_STRB} into FIFO2 and W_Address into FIFO3 together when W_Valid=1 and full2=0; when full, the request is dropped.
REQ-005 SHALL push R_Address into FIFO4 when R_Valid_Address_x=1 and R_Ready_Address=1.
REQ-006 SHALL present the FIFO1 head on R_Data (0 when empty) and pop it when R_Ready=1 and empty1=0; simultaneous push and pop are both honoured.
REQ-007 SHALL map addresses as col=addr[5:0], bank=addr[7:6], row=addr[16:8].
REQ-008 SHALL encode CA as: ACT={3'b001,bank,row}; WR={3'b010,bank,3'b000,col}; RD={3'b011,bank,3'b000,col}; PRE={3'b100,bank,9'h0}; CA=0 whenever CS=1.
REQ-009 SHALL run an FSM with states IDLE, ACT, TRCD_W, CMD, LAT_W, DATA0, DATA1, PRE, TRP_W.
REQ-010 IDLE: if a request is pending, pop it and go to ACT; writes win when both FIFOs are non-empty.
REQ-011 SHALL hold CS=0 for exactly one cycle in each of ACT, CMD and PRE, and CS=1 otherwise.
REQ-012 SHALL wait TRCD cycles after ACT, WLAT (write) or RLAT (read) cycles after CMD, and TRP cycles after PRE.
REQ-013 Write: DATA0 drives DQ=data[15:0], DATA1 drives DQ=data[31:16]; DQ SHALL be high-Z in all other states.
REQ-014 Read: SHALL sample DQ into data[15:0] in DATA0 and into data[31:16] in DATA1, then push to FIFO1 with err=0.
REQ-015 Reads SHALL stall in IDLE while FIFO1 is full.
REQ-016 A popped write with W_STRB=4'h0 SHALL be discarded with no DRAM command; any non-zero strobe writes the full word (no mask pin).
REQ-017 A read with R_Address[31:17]!=0 SHALL push {err=1, data=0} to FIFO1 with no DRAM command; R_Error = head err flag AND !empty1.

Reset
REQ-018 rst_n=0 SHALL asynchronously:
- empty all FIFOs (empty*=1, full*=0, R_Ready_Address=1)
- set R_Data=0, R_Error=0
- set CS=1, CA=0, DQ=Z
- force FSM to IDLE, aborting any in-flight command; the aborted request is lost.

Configuration
REQ-019 With RD_PRIORITY_EN defined, reads SHALL win the IDLE arbitration; without it, writes win (REQ-010).

Structure
REQ-020 SHALL put the CA opcode constants, FSM state encoding and address field positions in shared package ddr5_ctrl_pkg.
REQ-021 SHALL instantiate a parameterised synchronous FIFO sub-module, sync_fifo, four times.

Verification
REQ-022 Write 0x14253679, STRB F, address 0x4567 -> CA ACT={001,01,0x045}; WR col 0x27; DQ 0x3679 then 0x1425; FIFO2/3 return to empty.
REQ-023 Write 0x5148AECF, STRB E, address 0x4568 -> ACT bank 01 row 0x045; WR col 0x28; DQ 0xAECF then 0x5148.
REQ-024 Read 0x4567 with the bench driving DQ 0xBEEF in DATA0 and 0xDEAD in DATA1 -> R_Data=0xDEADBEEF, empty1=0 held until R_Ready=1, R_Error=0.
REQ-025 Read 0x00020000 -> no CS pulse; R_Data=0; R_Error=1 until popped.
REQ-026 Five back-to-back writes while the FSM is busy -> full2=full3=1 after the fourth, the fifth is dropped, and four WR commands issue.
REQ-027 Assert rst_n=0 during LAT_W -> CS=1, DQ=Z, all empty*=1 immediately; no PRE issued.
